// File: rtl/key_debounce.sv
// Push-button debouncer: 2-flop synchronizer feeding a press/release filter FSM with
// one-cycle press, release and long-press pulses.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key,
  output logic key_value,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned CntW  = $clog2(LONG_CYCLES) + 1;
  localparam int unsigned FcntW = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [CntW-1:0]  CntOne    = CntW'(1);
  localparam logic [CntW-1:0]  CntDebEnd = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0]  CntLong   = CntW'(LONG_CYCLES);
  localparam logic [CntW-1:0]  CntLongM1 = CntW'(LONG_CYCLES - 1);
  localparam logic [FcntW-1:0] FcntOne   = FcntW'(1);
  localparam logic [FcntW-1:0] FcntEnd   = FcntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressFilt,
    StPressed,
    StRelFilt
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic              key_s;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [FcntW-1:0]  fcnt_q, fcnt_d;
  logic              value_q, value_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  assign key_s = sync_q[1];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q    <= 2'b11;
      state_q   <= StIdle;
      cnt_q     <= '0;
      fcnt_q    <= '0;
      value_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      value_q   <= value_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fcnt_d    = fcnt_q;
    value_d   = value_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!key_s) begin
          state_d = StPressFilt;
          cnt_d   = CntOne;
        end else begin
          cnt_d = '0;
        end
      end
      StPressFilt: begin
        if (key_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntDebEnd) begin
          state_d = StPressed;
          value_d = 1'b0;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StPressed: begin
        // Saturation means the LONG-1 -> LONG step happens once per press.
        if (cnt_q != CntLong) begin
          cnt_d  = cnt_q + CntOne;
          long_d = (cnt_q == CntLongM1);
        end
        if (key_s) begin
          state_d = StRelFilt;
          fcnt_d  = FcntOne;
        end
      end
      StRelFilt: begin
        if (!key_s) begin
          state_d = StPressed;
          fcnt_d  = '0;
        end else if (fcnt_q == FcntEnd) begin
          state_d   = StIdle;
          value_d   = 1'b1;
          release_d = 1'b1;
          cnt_d     = '0;
          fcnt_d    = '0;
        end else begin
          fcnt_d = fcnt_q + FcntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign key_value   = value_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random key/reset activity, checked every
// cycle against a run-length model of the debouncer.
module tb_key_debounce;

  localparam int Deb  = 4;
  localparam int Long = 20;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key     = 1'b1;
  logic key_value, key_press, key_release, key_long;

  key_debounce #(
    .DEBOUNCE_CYCLES(Deb),
    .LONG_CYCLES    (Long)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key        (key),
    .key_value  (key_value),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: the synchronized key is the raw key two edges late; an edge is accepted when
  // the current run of equal samples reaches Deb. Hold time counts edges spent pressed
  // with no pending high sample.
  int cyc = 0;
  bit m_s1 = 1'b1, m_s2 = 1'b1, m_ks;
  int low_run = 0, high_run = 0, hold = 0;
  bit m_val = 1'b1, m_press = 1'b0, m_rel = 1'b0, m_long = 1'b0;

  always @(posedge sys_clk) begin
    cyc++;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (sys_rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      low_run = 0; high_run = 0; hold = 0;
      m_val = 1'b1;
    end else begin
      m_ks = m_s2;
      if (!m_val && high_run == 0 && hold < Long) begin
        hold++;
        if (hold == Long) m_long = 1'b1;
      end
      if (m_ks) begin high_run++; low_run = 0; end
      else begin low_run++; high_run = 0; end
      if (m_val && low_run == Deb) begin
        m_val = 1'b0; m_press = 1'b1; hold = 0;
      end else if (!m_val && high_run == Deb) begin
        m_val = 1'b1; m_rel = 1'b1;
      end
      m_s2 = m_s1;
      m_s1 = key;
    end
  end

  // Per-cycle compare plus pulse bookkeeping for the directed checks.
  bit armed = 1'b0;
  int n_press = 0, n_rel = 0, n_long = 0;
  int p_cyc = -1, r_cyc = -1, l_cyc = -1;

  always @(negedge sys_clk) begin
    if (armed) begin
      check("outputs{value,press,release,long}",
            int'({key_value, key_press, key_release, key_long}),
            int'({m_val, m_press, m_rel, m_long}));
      if (key_press)   begin n_press++; p_cyc = cyc; end
      if (key_release) begin n_rel++;   r_cyc = cyc; end
      if (key_long)    begin n_long++;  l_cyc = cyc; end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic clr();
    n_press = 0; n_rel = 0; n_long = 0;
    p_cyc = -1; r_cyc = -1; l_cyc = -1;
  endtask

  int e0, r;

  initial begin
    step(1);
    armed = 1'b1;
    step(2);
    check("reset value", int'(key_value), 1);
    check("reset pulses", int'({key_press, key_release, key_long}), 0);
    sys_rst = 1'b0;
    step(5);

    // Clean press held 30 cycles, then release.
    clr();
    key = 1'b0; e0 = cyc + 1;
    step(30);
    check("clean press count", n_press, 1);
    check("clean press latency", p_cyc - e0, 5);
    check("clean value low", int'(key_value), 0);
    check("clean long count", n_long, 1);
    check("clean long latency", l_cyc - e0, 25);
    key = 1'b1;
    step(10);
    check("clean release count", n_rel, 1);

    // Bounce train with 2-cycle segments.
    clr();
    for (int i = 0; i < 10; i++) begin
      key = i[0];
      step(2);
    end
    key = 1'b1;
    step(10);
    check("bounce pulses", n_press + n_rel + n_long, 0);
    check("bounce value", int'(key_value), 1);

    // Press held 10 cycles after acceptance, then clean release.
    clr();
    key = 1'b0;
    step(15);
    key = 1'b1; e0 = cyc + 1;
    step(10);
    check("release count", n_rel, 1);
    check("release latency", r_cyc - e0, 5);
    check("release no long", n_long, 0);
    check("release value", int'(key_value), 1);

    // Release bounce while pressed; long press still fires once.
    clr();
    key = 1'b0;
    step(10);
    key = 1'b1;
    step(2);
    key = 1'b0;
    step(30);
    check("rel bounce no release", n_rel, 0);
    check("rel bounce long once", n_long, 1);
    key = 1'b1;
    step(10);
    check("rel bounce final release", n_rel, 1);
    check("rel bounce long still once", n_long, 1);

    // Reset mid-press with key held low.
    clr();
    key = 1'b0;
    step(9);
    sys_rst = 1'b1;
    step(1);
    check("mid reset value", int'(key_value), 1);
    check("mid reset pulses", int'({key_press, key_release, key_long}), 0);
    sys_rst = 1'b0; e0 = cyc + 1;
    n_press = 0;
    step(15);
    check("post reset press count", n_press, 1);
    check("post reset press latency", p_cyc - e0, 5);
    check("post reset no release", n_rel, 0);
    key = 1'b1;
    step(10);

    // Minimum width: 3 low samples rejected, 4 accepted.
    clr();
    key = 1'b0;
    step(3);
    key = 1'b1;
    step(10);
    check("min width 3 press", n_press, 0);
    key = 1'b0;
    step(4);
    key = 1'b1;
    step(15);
    check("min width 4 press", n_press, 1);
    check("min width 4 release", n_rel, 1);

    // Random key activity with occasional resets.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        sys_rst = 1'b1;
        step(1);
        sys_rst = 1'b0;
      end else begin
        key = 1'($urandom_range(0, 1));
        step(r < 70 ? $urandom_range(1, 6) : $urandom_range(4, 30));
      end
    end
    key = 1'b1;
    step(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000 (20 ms at 50 MHz): consecutive stable synchronized samples needed to accept an edge; legal range 2..2^24.
REQ-002 SHALL have parameter LONG_CYCLES, default 50_000_000 (1 s at 50 MHz): held-pressed duration that triggers key_long; must exceed DEBOUNCE_CYCLES.
REQ-003 SHALL have port sys_clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 SHALL have port sys_rst, input, 1 bit: reset; synchronous, active-high.
REQ-005 SHALL have port key, input, 1 bit: raw asynchronous push-button; active-low, 0 = pressed.
REQ-006 SHALL have port key_value, output, 1 bit: debounced level; active-low, same polarity as key.
REQ-007 SHALL have port key_press, output, 1 bit: one-cycle pulse on an accepted press.
REQ-008 SHALL have port key_release, output, 1 bit: one-cycle pulse on an accepted release.
REQ-009 SHALL have port key_long, output, 1 bit: one-cycle pulse, at most once per press.

Function
REQ-010 SHALL pass key through a 2-flop synchronizer; the second-flop output is key_s, and only key_s feeds the FSM.
REQ-011 SHALL implement a 4-state FSM: IDLE, PRESS_FILT, PRESSED, REL_FILT.
REQ-012 In IDLE with key_s=0: SHALL go to PRESS_FILT with cnt=1; otherwise SHALL stay in IDLE with cnt=0.
REQ-013 In PRESS_FILT with key_s=1 (bounce): SHALL return to IDLE with cnt=0 and emit no pulse.
REQ-014 In PRESS_FILT with key_s=0 and cnt=DEBOUNCE_CYCLES-1: SHALL go to PRESSED, set key_value=0, pulse key_press, and load cnt=0; otherwise SHALL increment cnt.
REQ-015 In PRESSED, cnt SHALL increment and saturate at LONG_CYCLES.
REQ-016 In PRESSED, key_long SHALL pulse on the single edge where cnt goes from LONG_CYCLES-1 to LONG_CYCLES.
REQ-017 In PRESSED with key_s=1: SHALL go to REL_FILT with a separate filter count fcnt=1; the long-press cnt SHALL be held.
REQ-018 In REL_FILT with key_s=0: SHALL return to PRESSED with fcnt=0; key_long SHALL NOT re-fire for the same press.
REQ-019 In REL_FILT with key_s=1 and fcnt=DEBOUNCE_CYCLES-1: SHALL go to IDLE, set key_value=1, pulse key_release, and clear cnt and fcnt; otherwise SHALL increment fcnt.
REQ-020 Latency: with E0 the first edge sampling raw key low and key stable thereafter, key_press SHALL be high in the cycle after edge E(1+DEBOUNCE_CYCLES); release timing is symmetric.
REQ-021 key_press, key_release and key_long SHALL each be registered, high for exactly one cycle, and never high together.
REQ-022 Counter widths SHALL be $clog2 of the respective limit plus 1; counters SHALL never wrap.
REQ-023 A bounce train with every stable segment shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no change on key_value.

Reset
REQ-024 When sys_rst=1 at a rising edge, the FSM SHALL go to IDLE, cnt and fcnt SHALL be 0, and both synchronizer flops SHALL be 1.
REQ-025 During and after reset: key_value=1 and key_press=key_release=key_long=0.
REQ-026 Reset asserted mid-press SHALL abort with no key_release pulse.
REQ-027 If key is still low after reset, a fresh full debounce SHALL occur, then a key_press pulse.
REQ-028 Reset SHALL take priority over every FSM transition in the same cycle.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-029 Clean press: key 1->0 held 30 cycles -> key_press once at E5, key_value=0 from E5, key_long once at E25.
REQ-030 Bounce: key toggles 0/1 every 2 cycles for 20 cycles then returns to 1 -> no pulses, key_value stays 1.
REQ-031 Release: after a press accepted and held 10 cycles, key=1 stable -> exactly one key_release, 5 edges after the first high sample; key_value=1; no key_long.
REQ-032 Release bounce: while pressed, key high 2 cycles then low -> stays PRESSED, no key_release, key_long fires at most once per press.
REQ-033 Reset mid-press: sys_rst pulsed 1 cycle at E10 while key is held low -> outputs at reset values; key_press re-fires 5 edges after reset deasserts; no key_release.
REQ-034 Minimum width: key low exactly 3 synchronized cycles -> no press; key low exactly 4 -> one key_press, then one key_release after the release filter.
